// File: rtl/dz_frame_capture.sv
// dz_frame_capture
// Receive-side monitor for the 8x8 red/green dot-matrix scan bus. Samples the
// active-low one-hot row strobes and the red/green column lines, debounces the
// {row,colr,colg} tuple, rebuilds an 8-row frame in a shadow buffer and copies
// it to an output buffer once row 7 lands. The output buffer is read through a
// registered port.
//
// Optional feature: define DZ_CAP_COLOR_EN to add the frame_color output.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   row[7:0]          row select, one-hot active-low, 8'hFF = blank
//   colr[7:0]         red column data, active-high
//   colg[7:0]         green column data, active-high
//   rd_addr[2:0]      read row index
//   rd_r/rd_g[7:0]    captured row data, 1-cycle read latency
//   frame_valid       one-cycle pulse per committed frame
//   frame_cnt[7:0]    committed frame count, wraps
//   onehot_err        pulse: accepted row had more than one low bit
//   seq_err           pulse: out-of-order row during capture
//   timeout           pulse: in-progress frame aborted by idle timeout
//   dbg_state         current FSM state (0 = IDLE, 1 = CAPTURE)
//   frame_color[1:0]  {green seen, red seen} of last frame (DZ_CAP_COLOR_EN)
//
// Handshake: there is no back-pressure. frame_valid is a single-cycle
// qualifier; the output buffer holds the new frame from the cycle after the
// pulse until the next commit.
module dz_frame_capture #(
  parameter int STABLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] row,
  input  logic [7:0] colr,
  input  logic [7:0] colg,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_r,
  output logic [7:0] rd_g,
  output logic       frame_valid,
  output logic [7:0] frame_cnt,
  output logic       onehot_err,
  output logic       seq_err,
  output logic       timeout,
  output logic       dbg_state
`ifdef DZ_CAP_COLOR_EN
  ,
  output logic [1:0] frame_color
`endif
);

  localparam logic [3:0] STAB_LIM = 4'(STABLE_CYC);
  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);

  typedef enum logic [0:0] {IDLE = 1'b0, CAPTURE = 1'b1} state_t;

  state_t state, state_n;

  logic [23:0]   sync1, sync2, tuple_q, acc_tuple;
  logic [3:0]    stab_cnt, cnt_n;
  logic          taken, taken_eff, same, acc, acc_n;
  logic [7:0]    row_sel;
  logic          is_blank, is_one, row_ok, to_fire;
  logic [2:0]    acc_idx, expected, exp_prev, exp_n;
  logic [TW-1:0] tmo_cnt;
  logic          wr_en, commit, seq_c, oh_c, to_c;
  logic [7:0]    shadow_r [8];
  logic [7:0]    shadow_g [8];
  logic [7:0]    out_r [8];
  logic [7:0]    out_g [8];

  // Stability filter. stab_cnt is the run length of the current sync2 value.
  // taken starts set so the all-zero reset contents are never accepted; any
  // change of the tuple re-arms a single acceptance.
  always_comb begin
    same      = (sync2 == tuple_q);
    cnt_n     = same ? ((stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1) : 4'd1;
    taken_eff = same && taken;
    acc_n     = !taken_eff && (cnt_n >= STAB_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      tuple_q   <= '0;
      stab_cnt  <= '0;
      taken     <= 1'b1;
      acc       <= 1'b0;
      acc_tuple <= '0;
    end else begin
      sync1     <= {row, colr, colg};
      sync2     <= sync1;
      tuple_q   <= sync2;
      stab_cnt  <= cnt_n;
      taken     <= taken_eff || acc_n;
      acc       <= acc_n;
      acc_tuple <= sync2;
    end
  end

  // Decode of the accepted row strobe.
  always_comb begin
    row_sel  = ~acc_tuple[23:16];
    is_blank = (row_sel == 8'h00);
    is_one   = !is_blank && ((row_sel & (row_sel - 8'd1)) == 8'h00);
    acc_idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (row_sel[i]) acc_idx = 3'(i);
    end
    row_ok   = acc && is_one;
    exp_prev = expected - 3'd1;
    // Any accepted non-blank row clears the counter, so it wins over timeout.
    to_fire  = (state == CAPTURE) && (tmo_cnt == TMO_LIM) && !(acc && !is_blank);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM: next state. Row 0 and the repeat row are checked before the expected
  // row so that, with expected == 1, row 0 is a plain restart.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (row_ok && acc_idx == 3'd0) state_n = CAPTURE;
      CAPTURE: begin
        if (to_fire) state_n = IDLE;
        else if (row_ok) begin
          if (acc_idx == 3'd0 || acc_idx == exp_prev) state_n = CAPTURE;
          else if (acc_idx == expected) state_n = (acc_idx == 3'd7) ? IDLE : CAPTURE;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs / datapath controls
  always_comb begin
    wr_en  = 1'b0;
    exp_n  = expected;
    commit = 1'b0;
    seq_c  = 1'b0;
    oh_c   = acc && !is_blank && !is_one;
    to_c   = to_fire;
    case (state)
      IDLE: begin
        if (row_ok && acc_idx == 3'd0) begin
          wr_en = 1'b1;
          exp_n = 3'd1;
        end
      end
      CAPTURE: begin
        if (!to_fire && row_ok) begin
          if (acc_idx == 3'd0) begin
            wr_en = 1'b1;
            exp_n = 3'd1;
          end else if (acc_idx == exp_prev) begin
            wr_en = 1'b1;
          end else if (acc_idx == expected) begin
            wr_en  = 1'b1;
            exp_n  = expected + 3'd1;
            commit = (acc_idx == 3'd7);
          end else begin
            seq_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

`ifdef DZ_CAP_COLOR_EN
  logic [7:0] r_any, g_any;
  always_comb begin
    r_any = acc_tuple[15:8];
    g_any = acc_tuple[7:0];
    for (int i = 0; i < 7; i++) begin
      r_any = r_any | shadow_r[i];
      g_any = g_any | shadow_g[i];
    end
  end
`endif

  // Datapath. Commit happens in the same edge that writes shadow row 7, so
  // row 7 is taken straight from the accepted tuple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow_r[i] <= '0;
        shadow_g[i] <= '0;
        out_r[i]    <= '0;
        out_g[i]    <= '0;
      end
      expected    <= '0;
      tmo_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      onehot_err  <= 1'b0;
      seq_err     <= 1'b0;
      timeout     <= 1'b0;
      rd_r        <= '0;
      rd_g        <= '0;
`ifdef DZ_CAP_COLOR_EN
      frame_color <= 2'b00;
`endif
    end else begin
      if (wr_en) begin
        shadow_r[acc_idx] <= acc_tuple[15:8];
        shadow_g[acc_idx] <= acc_tuple[7:0];
      end
      if (commit) begin
        for (int i = 0; i < 7; i++) begin
          out_r[i] <= shadow_r[i];
          out_g[i] <= shadow_g[i];
        end
        out_r[7] <= acc_tuple[15:8];
        out_g[7] <= acc_tuple[7:0];
`ifdef DZ_CAP_COLOR_EN
        frame_color <= {|g_any, |r_any};
`endif
      end
      expected <= exp_n;
      if (state == IDLE || to_fire || (acc && !is_blank)) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LIM)                        tmo_cnt <= tmo_cnt + 1'b1;
      frame_valid <= commit;
      frame_cnt   <= frame_cnt + {7'd0, commit};
      onehot_err  <= oh_c;
      seq_err     <= seq_c;
      timeout     <= to_c;
      rd_r        <= out_r[rd_addr];
      rd_g        <= out_g[rd_addr];
    end
  end

endmodule

// File: tb/tb_dz_frame_capture.sv
// Testbench for dz_frame_capture: directed scan-bus frames, an event
// scoreboard for the pulse outputs and directed read-port checks.
module tb_dz_frame_capture;

  localparam int STABLE_CYC  = 2;
  localparam int TIMEOUT_CYC = 1000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] row, colr, colg, rd_r, rd_g, frame_cnt;
  logic [2:0] rd_addr;
  logic       frame_valid, onehot_err, seq_err, timeout, dbg_state;
`ifdef DZ_CAP_COLOR_EN
  logic [1:0] frame_color;
`endif

  dz_frame_capture #(.STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .colr(colr), .colg(colg),
    .rd_addr(rd_addr), .rd_r(rd_r), .rd_g(rd_g), .frame_valid(frame_valid),
    .frame_cnt(frame_cnt), .onehot_err(onehot_err), .seq_err(seq_err),
    .timeout(timeout), .dbg_state(dbg_state)
`ifdef DZ_CAP_COLOR_EN
    , .frame_color(frame_color)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Event word: {frame_valid, onehot_err, seq_err, timeout, frame_cnt}
  logic [11:0] exp_q[$];
  logic [11:0] got_ev, exp_ev;
  logic [7:0]  exp_r [8];
  logic [7:0]  exp_g [8];
  logic [7:0]  fcnt_model = 8'd0;

  function automatic logic [7:0] rsel(input int i);
    logic [7:0] one;
    one = 8'h01 << i;
    return ~one;
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic push_ev(input logic fv, input logic oh, input logic se, input logic to);
    exp_q.push_back({fv, oh, se, to, fcnt_model});
  endtask

  // driver tasks
  task automatic send_row(input logic [7:0] r_sel, input logic [7:0] cr,
                          input logic [7:0] cg, input int hold);
    @(posedge clk); #1;
    row = r_sel; colr = cr; colg = cg;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic blank(input int n);
    send_row(8'hFF, 8'h00, 8'h00, n);
  endtask

  // Full frame rows 0..7 with colr = br + sr*i, colg = bg + sr*i.
  // mh_at: insert a multi-hot row before that row; glitch_at: 1-cycle F7 spike.
  task automatic send_frame(input logic [7:0] br, input logic [7:0] bg,
                            input logic [7:0] sr, input int mh_at, input int glitch_at);
    logic [7:0] cr, cg;
    for (int i = 0; i < 8; i++) begin
      cr = 8'(br + sr * i);
      cg = 8'(bg + sr * i);
      if (i == mh_at) begin
        push_ev(1'b0, 1'b1, 1'b0, 1'b0);
        send_row(8'hFC, 8'h11, 8'h22, 4);
      end
      if (i == 7) begin
        fcnt_model++;
        push_ev(1'b1, 1'b0, 1'b0, 1'b0);
      end
      if (i == glitch_at) begin
        send_row(rsel(i), cr, cg, 3);
        send_row(8'hF7, cr, cg, 1);
        send_row(rsel(i), cr, cg, 4);
      end else begin
        send_row(rsel(i), cr, cg, 4);
      end
      exp_r[i] = cr;
      exp_g[i] = cg;
    end
  endtask

  task automatic read_chk(input int addr);
    @(posedge clk); #1;
    rd_addr = 3'(addr);
    @(posedge clk); #1;
    check8($sformatf("rd_r[%0d]", addr), rd_r, exp_r[addr]);
    check8($sformatf("rd_g[%0d]", addr), rd_g, exp_g[addr]);
  endtask

  // scoreboard monitor: pops one expected event per observed pulse
  always @(negedge clk) begin
    if (rst_n && (frame_valid || onehot_err || seq_err || timeout)) begin
      got_ev = {frame_valid, onehot_err, seq_err, timeout, frame_cnt};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got %03h expected none", got_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (got_ev !== exp_ev) begin
          mismatched++;
          $display("FAIL event: got %03h expected %03h", got_ev, exp_ev);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] old_r, old_g;
    bit seen;
    row = 8'hFF; colr = 8'h00; colg = 8'h00; rd_addr = 3'd0;
    for (int i = 0; i < 8; i++) begin
      exp_r[i] = 8'h00;
      exp_g[i] = 8'h00;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check8("reset_frame_cnt", frame_cnt, 8'h00);
    check8("reset_rd_r", rd_r, 8'h00);
    check8("reset_rd_g", rd_g, 8'h00);
    check8("reset_pulses", {4'd0, frame_valid, onehot_err, seq_err, timeout}, 8'h00);
    check8("reset_state", {7'd0, dbg_state}, 8'h00);
    rst_n = 1'b1;
    blank(8);

    // clean frame
    send_frame(8'h7E, 8'h00, 8'h00, -1, -1);
    blank(10);
    check8("clean_frame_cnt", frame_cnt, 8'd1);
    for (int a = 0; a < 8; a++) read_chk(a);
`ifdef DZ_CAP_COLOR_EN
    check8("clean_color", {6'd0, frame_color}, 8'h01);
`endif

    // out-of-order: rows 0,1,3
    send_row(rsel(0), 8'h01, 8'h01, 4);
    send_row(rsel(1), 8'h02, 8'h02, 4);
    push_ev(1'b0, 1'b0, 1'b1, 1'b0);
    send_row(rsel(3), 8'h03, 8'h03, 4);
    blank(10);
    read_chk(3);
    send_frame(8'h10, 8'h80, 8'h01, -1, -1);
    blank(10);
    read_chk(0);
    read_chk(5);

    // multi-hot row between rows 2 and 3
    send_frame(8'hA0, 8'h50, 8'h01, 3, -1);
    blank(10);
    read_chk(2);
    read_chk(3);

    // timeout: rows 0..4 then long blank; output buffer must hold
    for (int i = 0; i < 5; i++) send_row(rsel(i), 8'hFF, 8'hFF, 4);
    push_ev(1'b0, 1'b0, 1'b0, 1'b1);
    blank(TIMEOUT_CYC + 5);
    for (int a = 0; a < 8; a++) read_chk(a);

    // glitch during the row-2 hold
    send_frame(8'h30, 8'h0C, 8'h02, -1, 2);
    blank(10);
    read_chk(2);
    read_chk(7);

    // read/commit collision on row 7
    @(posedge clk); #1;
    rd_addr = 3'd7;
    old_r = exp_r[7];
    old_g = exp_g[7];
    for (int i = 0; i < 7; i++) send_row(rsel(i), 8'(8'hC0 + i), 8'(8'h03 + i), 4);
    fcnt_model++;
    push_ev(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    row = rsel(7); colr = 8'hE7; colg = 8'h7E;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (frame_valid) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL collision_wait: got no frame_valid expected pulse within 20 cycles");
    end else begin
      check8("collision_old_r", rd_r, old_r);
      check8("collision_old_g", rd_g, old_g);
      @(posedge clk); #1;
      check8("collision_new_r", rd_r, 8'hE7);
      check8("collision_new_g", rd_g, 8'h7E);
    end
    for (int i = 0; i < 7; i++) begin
      exp_r[i] = 8'(8'hC0 + i);
      exp_g[i] = 8'(8'h03 + i);
    end
    exp_r[7] = 8'hE7;
    exp_g[7] = 8'h7E;
    blank(6);

    // run frames until frame_cnt wraps to 0
    for (int f = 0; f < 251; f++) begin
      send_frame(8'(f), 8'(~f), 8'h01, -1, -1);
      blank(2);
    end
    blank(10);
    check8("wrap_frame_cnt", frame_cnt, fcnt_model);
    check8("wrap_is_zero", frame_cnt, 8'h00);
    read_chk(4);

    blank(20);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
